// File: rtl/spart_rx_engine_if.sv
// Received-byte stream from the UART RX engine to the RX queue.
// The master drives rx_data/rx_valid and the slave drives rx_ready.
interface spart_rx_engine_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/spart_rx_engine.sv
// UART receiver: synchronizer, mid-bit sampling FSM, one-entry output register.
// Byte is valid the cycle after the stop-bit tick; a full output register drops new bytes (overrun).
module spart_rx_engine #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_DIV     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     RX,
  input  logic [12:0]              baud_div,
  spart_rx_engine_if.master        rxq,
  output logic                     busy,
  output logic                     frame_err,
  output logic                     overrun
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] rx_sync;
  logic                   rx_s;
  logic [12:0]            div, bit_cnt, div_in;
  logic [2:0]             bit_idx;
  logic [7:0]             shift;
  logic [7:0]             rx_data_q;
  logic                   rx_valid_q;
  logic                   tick, start_det, sample_bit, done, ferr_det;

  assign rx_s   = rx_sync[SYNC_STAGES-1];
  assign div_in = (baud_div < 13'(MIN_DIV)) ? 13'(MIN_DIV) : baud_div;
  assign tick   = (bit_cnt == '0);
  assign busy   = (state != IDLE);

  assign rxq.rx_data  = rx_data_q;
  assign rxq.rx_valid = rx_valid_q;

  always_ff @(posedge clk) begin
    if (rst) rx_sync <= '1;
    else     rx_sync <= {rx_sync[SYNC_STAGES-2:0], RX};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start_det  = 1'b0;
    sample_bit = 1'b0;
    done       = 1'b0;
    ferr_det   = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          start_det = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (tick) state_nxt = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (tick) begin
          sample_bit = 1'b1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (rx_s) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_det  = 1'b1;
            state_nxt = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // A held-low line (break) must not retrigger until it has gone high once.
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Half a bit time to the first tick centres every later sample in its bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      div     <= '0;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      if (start_det) begin
        div     <= div_in;
        bit_cnt <= div_in >> 1;
      end else if (state == START || state == DATA || state == STOP) begin
        bit_cnt <= tick ? (div - 13'd1) : (bit_cnt - 13'd1);
      end
      if (state == START) bit_idx <= '0;
      if (sample_bit) begin
        shift   <= {rx_s, shift[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= ferr_det;
      overrun   <= 1'b0;
      if (rx_valid_q && rxq.rx_ready) rx_valid_q <= 1'b0;
      if (done) begin
        if (!rx_valid_q || rxq.rx_ready) begin
          rx_data_q  <= shift;
          rx_valid_q <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spart_rx_engine.sv
// Directed scenarios for spart_rx_engine, checked every cycle against a frame-timing model.
module tb_spart_rx_engine;
  localparam int SYNC    = 2;
  localparam int MIN_DIV = 4;
  localparam int NMAX    = 14000;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_line;
  logic [12:0] baud_div;
  logic        busy, frame_err, overrun;

  spart_rx_engine_if rif();

  spart_rx_engine #(.SYNC_STAGES(SYNC), .MIN_DIV(MIN_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .RX        (rx_line),
    .baud_div  (baud_div),
    .rxq       (rif.master),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #10 clk = ~clk;

  // Stimulus per cycle and model expectations per cycle
  logic       rx_arr [NMAX];
  logic       rst_arr[NMAX];
  logic       rdy_arr[NMAX];
  logic       exp_v  [NMAX];
  logic       exp_busy[NMAX];
  logic       exp_fe [NMAX];
  logic       exp_ov [NMAX];
  logic [7:0] exp_d  [NMAX];
  logic       comp_vld [NMAX];
  logic [7:0] comp_byte[NMAX];
  int n, baud_cfg, snap_c;

  int errors = 0;
  int checks = 0;
  int first_v, v_cnt, fe_cnt, fe_first, ov_cnt, ov_first, busy_cnt, busy_last, snap;
  int got_q[$];

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  function automatic int cdiv();
    return (baud_cfg < MIN_DIV) ? MIN_DIV : baud_cfg;
  endfunction

  function automatic int qat(input int i);
    return (got_q.size() > i) ? got_q[i] : -1;
  endfunction

  // Synchronized line as seen by the receiver in cycle c
  function automatic logic rxs_m(input int c);
    if (c - SYNC < 0) return 1'b1;
    for (int q = c - SYNC; q <= c - 1; q++)
      if (rst_arr[q]) return 1'b1;
    return rx_arr[c - SYNC];
  endfunction

  task automatic new_scn(input int len, input int baud);
    n = len;
    baud_cfg = baud;
    snap_c = -1;
    for (int i = 0; i < NMAX; i++) begin
      rx_arr[i] = 1'b1; rst_arr[i] = 1'b0; rdy_arr[i] = 1'b1;
    end
    rst_arr[0] = 1'b1;
    rst_arr[1] = 1'b1;
  endtask

  task automatic put_level(input int a, input int b, input logic val);
    for (int i = a; i <= b && i < n; i++) rx_arr[i] = val;
  endtask

  task automatic put_frame(input int e, input logic [7:0] byt, input logic stop_b);
    logic val;
    for (int i = 0; i < 10; i++) begin
      val = (i == 0) ? 1'b0 : (i == 9) ? stop_b : byt[i-1];
      put_level(e + i * cdiv(), e + (i + 1) * cdiv() - 1, val);
    end
  endtask

  // Frames are located on the synchronized line, then sampled at fixed bit-time offsets.
  task automatic build_model();
    int c, t, ts, sp, last, q, w, div, h, comp_c, fe_c;
    logic [7:0] b, d;
    logic v, ov, was;
    div = cdiv();
    h = div / 2;
    for (int i = 0; i < NMAX; i++) begin
      exp_busy[i] = 0; exp_fe[i] = 0; exp_v[i] = 0; exp_ov[i] = 0; exp_d[i] = 0;
      comp_vld[i] = 0; comp_byte[i] = 0;
    end
    c = 1;
    while (c < n) begin
      if (rst_arr[c] || rxs_m(c)) begin
        c++;
        continue;
      end
      t = c; ts = t + 1 + h; sp = ts + 9 * div; comp_c = -1; fe_c = -1; b = 0;
      if (ts >= n) last = n - 1;
      else if (rxs_m(ts)) last = ts;
      else if (sp >= n) last = n - 1;
      else begin
        for (int k = 1; k <= 8; k++) b[k-1] = rxs_m(ts + k * div);
        if (rxs_m(sp)) begin
          comp_c = sp; last = sp;
        end else begin
          fe_c = sp + 1; w = sp + 1;
          while (w < n - 1 && !rxs_m(w)) w++;
          last = w;
        end
      end
      q = -1;
      for (int i = t; i <= last; i++) if (q < 0 && rst_arr[i]) q = i;
      if (q >= 0) begin
        if (q <= sp) begin comp_c = -1; fe_c = -1; end
        last = q;
      end
      for (int i = t + 1; i <= last && i < n; i++) exp_busy[i] = 1;
      if (comp_c >= 0) begin comp_vld[comp_c] = 1; comp_byte[comp_c] = b; end
      if (fe_c >= 0 && fe_c < n) exp_fe[fe_c] = 1;
      c = last + 1;
    end
    v = 0; d = 0;
    for (int i = 1; i < n; i++) begin
      exp_v[i] = v; exp_d[i] = d;
      ov = 0;
      if (rst_arr[i]) begin
        v = 0; d = 0;
      end else begin
        was = v;
        if (was && rdy_arr[i]) v = 0;
        if (comp_vld[i]) begin
          if (!was || rdy_arr[i]) begin v = 1; d = comp_byte[i]; end
          else ov = 1;
        end
      end
      if (i + 1 < n) exp_ov[i+1] = ov;
    end
  endtask

  function automatic int model_first_v();
    for (int i = 0; i < n; i++) if (exp_v[i]) return i;
    return -1;
  endfunction

  task automatic run_scn(input string tag);
    logic [11:0] got, want;
    build_model();
    got_q.delete();
    first_v = -1; v_cnt = 0; fe_cnt = 0; fe_first = -1; ov_cnt = 0; ov_first = -1;
    busy_cnt = 0; busy_last = -1; snap = -1;
    for (int c = 0; c < n; c++) begin
      rx_line = rx_arr[c];
      rst = rst_arr[c];
      rif.rx_ready = rdy_arr[c];
      baud_div = 13'(baud_cfg);
      @(posedge clk);
      #1;
      if (c + 1 < n) begin
        got  = {rif.rx_valid, busy, frame_err, overrun, rif.rx_data};
        want = {exp_v[c+1], exp_busy[c+1], exp_fe[c+1], exp_ov[c+1], exp_d[c+1]};
        chk($sformatf("%s cyc%0d {vld,busy,ferr,ovr,data}", tag, c + 1), int'(got), int'(want));
        if (rif.rx_valid) begin
          v_cnt++;
          if (first_v < 0) first_v = c + 1;
          if (rdy_arr[c+1]) got_q.push_back(int'(rif.rx_data));
        end
        if (frame_err) begin fe_cnt++; if (fe_first < 0) fe_first = c + 1; end
        if (overrun) begin ov_cnt++; if (ov_first < 0) ov_first = c + 1; end
        if (busy) begin busy_cnt++; busy_last = c + 1; end
        if (c + 1 == snap_c) snap = int'(got);
      end
    end
  endtask

  initial begin
    rst = 1'b1; rx_line = 1'b1; rif.rx_ready = 1'b0; baud_div = 13'd16;

    // Single byte 0xA5 at div 16
    new_scn(250, 16);
    put_frame(20, 8'hA5, 1'b1);
    run_scn("a5");
    chk("a5 model_first_valid", model_first_v(), 176);
    chk("a5 first_valid_cycle", first_v, 176);
    chk("a5 valid_cycles", v_cnt, 1);
    chk("a5 data", qat(0), 8'hA5);
    chk("a5 busy_cycles", busy_cnt, 153);

    // Three back-to-back bytes at 115200 baud
    new_scn(12900, 13'h1B2);
    put_frame(20, 8'h00, 1'b1);
    put_frame(20 + 4340, 8'hFF, 1'b1);
    put_frame(20 + 8680, 8'h3C, 1'b1);
    run_scn("b2b");
    chk("b2b model_first_valid", model_first_v(), 4147);
    chk("b2b handshakes", got_q.size(), 3);
    chk("b2b byte0", qat(0), 8'h00);
    chk("b2b byte1", qat(1), 8'hFF);
    chk("b2b byte2", qat(2), 8'h3C);
    chk("b2b error_pulses", fe_cnt + ov_cnt, 0);

    // Five-cycle glitch is a false start
    new_scn(80, 16);
    put_level(20, 24, 1'b0);
    run_scn("false");
    chk("false busy_cycles", busy_cnt, 9);
    chk("false busy_last", busy_last, 31);
    chk("false valid_cycles", v_cnt, 0);
    chk("false pulses", fe_cnt + ov_cnt, 0);

    // Bad stop bit followed by a break lasting three frames
    new_scn(720, 16);
    put_frame(20, 8'h55, 1'b0);
    put_level(164, 659, 1'b0);
    run_scn("break");
    chk("break ferr_count", fe_cnt, 1);
    chk("break ferr_cycle", fe_first, 176);
    chk("break valid_cycles", v_cnt, 0);
    chk("break busy_last", busy_last, 662);

    // Full output register: second byte is dropped
    new_scn(360, 16);
    put_frame(20, 8'h11, 1'b1);
    put_frame(180, 8'h22, 1'b1);
    for (int i = 0; i < 340; i++) rdy_arr[i] = 1'b0;
    snap_c = 338;
    run_scn("ovr");
    chk("ovr overrun_count", ov_cnt, 1);
    chk("ovr overrun_cycle", ov_first, 336);
    chk("ovr held_output", snap, 12'h811);

    // Consume coincides with completion: new byte replaces old without overrun
    new_scn(360, 16);
    put_frame(20, 8'h11, 1'b1);
    put_frame(180, 8'h22, 1'b1);
    for (int i = 0; i < 360; i++) rdy_arr[i] = 1'b0;
    rdy_arr[335] = 1'b1;
    snap_c = 336;
    run_scn("swap");
    chk("swap overrun_count", ov_cnt, 0);
    chk("swap new_output", snap, 12'h822);

    // Reset in data bit 4, then a clean frame
    new_scn(420, 16);
    put_frame(20, 8'h00, 1'b1);
    put_level(102, 199, 1'b1);
    rst_arr[100] = 1'b1;
    rst_arr[101] = 1'b1;
    put_frame(200, 8'h5A, 1'b1);
    snap_c = 102;
    run_scn("rst");
    chk("rst outputs_after_reset", snap, 0);
    chk("rst valid_cycles", v_cnt, 1);
    chk("rst first_valid_cycle", first_v, 356);
    chk("rst data", qat(0), 8'h5A);
    chk("rst pulses", fe_cnt + ov_cnt, 0);

    // Divisor below the minimum is clamped
    new_scn(100, 1);
    put_frame(20, 8'hC3, 1'b1);
    run_scn("clamp");
    chk("clamp first_valid_cycle", first_v, 62);
    chk("clamp data", qat(0), 8'hC3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spart_rx_engine.md
SPART_RX_ENGINE -- requirements
Module: spart_rx_engine

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of flops in the RX input synchronizer (legal range 2..4).
REQ-002 SHALL have parameter MIN_DIV, default 4, smallest baud divisor honoured; smaller programmed values are clamped to it.
REQ-003 SHALL have port clk  input  1  single system clock, 50 MHz nominal, all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port RX  input  1  asynchronous UART serial line, idle high.
REQ-006 SHALL have port baud_div  input  13  clk cycles per bit time, from DBH[4:0] and DBL; 0x1B2 gives 115200 baud.
REQ-007 SHALL have port rx_data  output  8  received byte presented to the RX queue.
REQ-008 SHALL have port rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-009 SHALL have port rx_ready  input  1  RX queue accepts rx_data this cycle.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-012 SHALL have port overrun  output  1  one-cycle pulse when a completed byte is dropped.

Function
REQ-013 SHALL pass RX through SYNC_STAGES flops, all reset to 1; only the synchronized value (rx_s) is used.
REQ-014 SHALL implement states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-015 SHALL, in IDLE with rx_s==0, latch div = max(baud_div, MIN_DIV), load the bit counter with div>>1, and enter START.
REQ-016 SHALL ignore baud_div changes while busy; the latched div governs the entire frame.
REQ-017 SHALL decrement the bit counter every cycle; a "tick" occurs when it reaches 0, at which point it reloads div-1 (a full bit time).
REQ-018 SHALL, at the START tick, return to IDLE if rx_s==1 (false start, no output, no pulse), else enter DATA with bit index 0.
REQ-019 SHALL, at each DATA tick, shift rx_s into the shift register LSB-first; after the 8th sample it SHALL enter STOP.
REQ-020 SHALL, at the STOP tick with rx_s==1, complete the byte and return to IDLE on the next cycle.
REQ-021 SHALL, at the STOP tick with rx_s==0, pulse frame_err, discard the byte, and enter WAIT_IDLE.
REQ-022 SHALL leave WAIT_IDLE for IDLE only on the first cycle rx_s==1, so a break condition yields exactly one frame_err.
REQ-023 SHALL, on completion with rx_valid==0, load rx_data and assert rx_valid in the next cycle.
REQ-024 SHALL clear rx_valid in the cycle after rx_valid&&rx_ready; rx_data SHALL be stable while rx_valid==1.
REQ-025 SHALL, on completion with rx_valid==1 and rx_ready==0, pulse overrun, drop the new byte, and keep rx_data/rx_valid unchanged.
REQ-026 SHALL, on completion coincident with rx_valid&&rx_ready, load the new byte, keep rx_valid==1, and not pulse overrun.
REQ-027 SHALL allow a new start bit to be detected in the cycle IDLE is re-entered (back-to-back frames, no gap required).
REQ-028 SHALL drive frame_err and overrun registered, never both in the same cycle.

Reset
REQ-029 SHALL, when rst==1 at a clk edge, force state IDLE, synchronizer flops 1, counters 0, and the shift register 0.
REQ-030 SHALL hold rx_data=0x00, rx_valid=0, busy=0, frame_err=0 and overrun=0 in the cycle after reset.
REQ-031 SHALL, on reset mid-frame, abandon the frame without any pulse and re-detect only on a later falling edge of rx_s.

Verification
REQ-032 SHALL check: baud_div=16, frame 0xA5 with rx_ready=1 -> rx_valid for exactly 1 cycle, rx_data=0xA5, ~152 cycles after the start edge.
REQ-033 SHALL check: baud_div=0x1B2, bytes 0x00, 0xFF, 0x3C sent back-to-back with no gap -> three rx_valid handshakes, data in order, no error pulses.
REQ-034 SHALL check: RX low for 5 cycles at baud_div=16 -> false start, busy drops, no rx_valid, no pulses.
REQ-035 SHALL check: stop bit driven 0, then RX held low for 3 frames -> exactly one frame_err, no rx_valid, busy until RX returns high.
REQ-036 SHALL check: rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, one overrun pulse; with rx_ready raised at the completion cycle, 0x22 is loaded and there is no overrun.
REQ-037 SHALL check: rst asserted during DATA bit 4, then a frame 0x5A sent -> outputs at reset values, then rx_data=0x5A received cleanly.
